// File: rtl/alu_requester_pkg.sv
// Shared definitions for the ALU requester and its responder: opcodes, FSM state
// codes, default widths and the LED display packing.
package alu_requester_pkg;

    localparam int DEF_ALU_WIDTH   = 4;
    localparam int DEF_OP_WIDTH    = 3;
    localparam int DEF_TIMEOUT_CYC = 16;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_NOT = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_CMP = 3'b110,
        OP_EQ  = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_REQ  = 3'd3,
        S_RESP = 3'd4,
        S_SHOW = 3'd5
    } state_e;

    // Display layout: count | busy | state | 0 | timeout | overflow | carry | result
    function automatic logic [15:0] pack_ledr(
        input logic [3:0] result,
        input logic       carry,
        input logic       overflow,
        input logic       timeout,
        input state_e     state,
        input logic       busy,
        input logic [3:0] count
    );
        return {count, busy, state, 1'b0, timeout, overflow, carry, result};
    endfunction

endpackage

// File: rtl/alu_requester_if.sv
// Request/response bus between the ALU requester (master) and ALU responder (slave).
interface alu_requester_if #(
    parameter int ALU_WIDTH = alu_requester_pkg::DEF_ALU_WIDTH,
    parameter int OP_WIDTH  = alu_requester_pkg::DEF_OP_WIDTH
);
    logic                 req_valid;
    logic                 req_ready;
    logic [OP_WIDTH-1:0]  req_op;
    logic [ALU_WIDTH-1:0] req_a;
    logic [ALU_WIDTH-1:0] req_b;
    logic                 resp_valid;
    logic [ALU_WIDTH-1:0] resp_result;
    logic                 resp_carry;
    logic                 resp_overflow;

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready, resp_valid, resp_result, resp_carry, resp_overflow
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready, resp_valid, resp_result, resp_carry, resp_overflow
    );
endinterface

// File: rtl/alu_requester_btn_pulse.sv
// Push-button conditioner: two-flop synchronizer followed by a rising-edge
// detector, so a held button produces exactly one single-cycle pulse.
module btn_pulse (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);
    logic sync1, sync2, prev;

    // NOTE: non-blocking assignments make each flop sample the previous stage's
    // old value, which is what turns these three registers into a shift chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign pulse = sync2 & ~prev;
endmodule

// File: rtl/alu_requester.sv
// Operator-driven ALU requester: enters A, B and opcode from switches, issues a
// valid/ready request, waits (bounded) for the response and displays it on LEDs.
module alu_requester
    import alu_requester_pkg::*;
#(
    parameter int ALU_WIDTH   = DEF_ALU_WIDTH,
    parameter int OP_WIDTH    = DEF_OP_WIDTH,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            sw,
    input  logic                   btn_enter,
    input  logic                   btn_clr,
    alu_requester_if.master        bus,
    output logic [15:0]            ledr,
    output logic                   busy
);
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

    state_e               state_q, state_d;
    logic [ALU_WIDTH-1:0] a_q, b_q, result_q;
    logic [OP_WIDTH-1:0]  op_q;
    logic                 carry_q, overflow_q, timeout_q;
    logic [3:0]           count_q;
    logic [WAIT_W-1:0]    wait_q;
    logic                 enter_pulse, clr_pulse, wait_expired;
    logic                 sw_unused;

    assign sw_unused = ^sw[12:4];

    btn_pulse u_enter (.clk(clk), .rst(rst), .btn(btn_enter), .pulse(enter_pulse));
    btn_pulse u_clr   (.clk(clk), .rst(rst), .btn(btn_clr),   .pulse(clr_pulse));

    // Last S_RESP cycle: the counter has counted TIMEOUT_CYC-1 idle cycles already.
    assign wait_expired = (wait_q == WAIT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_A;
        else     state_q <= state_d;
    end

    // NOTE: state_d is defaulted before the case so every path assigns it and
    // no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (clr_pulse) begin
            state_d = S_A;
        end else begin
            case (state_q)
                S_A:     if (enter_pulse) state_d = S_B;
                S_B:     if (enter_pulse) state_d = S_OP;
                S_OP:    if (enter_pulse) state_d = S_REQ;
                S_REQ:   if (bus.req_ready) state_d = S_RESP;
                S_RESP:  if (bus.resp_valid || wait_expired) state_d = S_SHOW;
                S_SHOW:  if (enter_pulse) state_d = S_A;
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            count_q    <= '0;
            wait_q     <= '0;
        end else if (clr_pulse) begin
            // Abandon entry/transaction; the displayed result and count survive.
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else begin
            case (state_q)
                S_A:  if (enter_pulse) a_q  <= ALU_WIDTH'(sw[3:0]);
                S_B:  if (enter_pulse) b_q  <= ALU_WIDTH'(sw[3:0]);
                S_OP: if (enter_pulse) op_q <= OP_WIDTH'(sw[15:13]);
                S_REQ: if (bus.req_ready) wait_q <= '0;
                S_RESP: begin
                    // A response on the expiry cycle still counts as a response.
                    if (bus.resp_valid) begin
                        result_q   <= bus.resp_result;
                        carry_q    <= bus.resp_carry;
                        overflow_q <= bus.resp_overflow;
                        timeout_q  <= 1'b0;
                        count_q    <= count_q + 4'd1;
                    end else if (wait_expired) begin
                        result_q   <= '0;
                        carry_q    <= 1'b0;
                        overflow_q <= 1'b0;
                        timeout_q  <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_valid = (state_q == S_REQ);
    assign bus.req_op    = op_q;
    assign bus.req_a     = a_q;
    assign bus.req_b     = b_q;
    assign busy          = (state_q == S_REQ) || (state_q == S_RESP);
    assign ledr          = pack_ledr(4'(result_q), carry_q, overflow_q, timeout_q,
                                     state_q, busy, count_q);
endmodule

// File: tb/tb_alu_requester.sv
// Self-checking bench for alu_requester: the bench plays the operator and the ALU
// responder, and a scoreboard queue holds the expected display per transaction.
module tb_alu_requester;
    import alu_requester_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sw = '0;
    logic        btn_enter = 1'b0;
    logic        btn_clr = 1'b0;
    logic [15:0] ledr;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [3:0]  m_result, m_count;
    logic        m_carry, m_ov, m_to;

    alu_requester_if #(.ALU_WIDTH(4), .OP_WIDTH(3)) bus ();

    alu_requester #(.ALU_WIDTH(4), .OP_WIDTH(3), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .sw(sw), .btn_enter(btn_enter), .btn_clr(btn_clr),
        .bus(bus), .ledr(ledr), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_ledr(input logic [2:0] st, input logic bsy);
        return {m_count, bsy, st, 1'b0, m_to, m_ov, m_carry, m_result};
    endfunction

    // Independent reference ALU used to generate responder data: {carry, ov, result}.
    function automatic logic [5:0] ref_alu(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
        logic [4:0] s;
        logic c, v;
        logic [3:0] r;
        c = 1'b0; v = 1'b0; r = '0; s = '0;
        case (op)
            3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4];
                          v = (a[3] == b[3]) && (r[3] != a[3]); end
            3'b001: begin r = a - b; c = (a < b); v = (a[3] != b[3]) && (r[3] != a[3]); end
            3'b010: r = ~a;
            3'b011: r = a & b;
            3'b100: r = a | b;
            3'b101: r = a ^ b;
            3'b110: r = (a < b) ? 4'd1 : 4'd0;
            default: r = (a == b) ? 4'd1 : 4'd0;
        endcase
        return {c, v, r};
    endfunction

    task automatic press_enter();
        btn_enter = 1'b1;
        repeat (4) @(negedge clk);
        btn_enter = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic press_clr();
        btn_clr = 1'b1;
        repeat (4) @(negedge clk);
        btn_clr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic enter_operands(input logic [3:0] a, input logic [3:0] b,
                                  input logic [2:0] op);
        sw = {12'h000, a}; press_enter();
        sw = {12'h000, b}; press_enter();
        sw = {op, 13'h0000}; press_enter();
    endtask

    // Full transaction; resp_cycle = k responds on the k-th S_RESP cycle, 0 = never.
    task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                           input int ready_delay, input int resp_cycle);
        logic [5:0]  r;
        logic [15:0] exp, got;
        bit          found;
        enter_operands(a, b, op);
        for (int i = 0; i <= ready_delay; i++) begin
            checks++;
            if (ledr[10:8] !== S_REQ || bus.req_valid !== 1'b1 || busy !== 1'b1 ||
                bus.req_a !== a || bus.req_b !== b || bus.req_op !== op) begin
                errors++;
                $display("FAIL req_hold[%0d]: state=%0d valid=%b busy=%b a=%h b=%h op=%h, want state=3 valid=1 busy=1 a=%h b=%h op=%h",
                         i, ledr[10:8], bus.req_valid, busy, bus.req_a, bus.req_b, bus.req_op, a, b, op);
            end
            if (i < ready_delay) @(negedge clk);
        end
        bus.req_ready = 1'b1;
        @(negedge clk);
        bus.req_ready = 1'b0;
        checks++;
        if (ledr[10:8] !== S_RESP || bus.req_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL resp_entry: state=%0d valid=%b busy=%b, want state=4 valid=0 busy=1",
                     ledr[10:8], bus.req_valid, busy);
        end
        if (resp_cycle > 0) begin
            r = ref_alu(op, a, b);
            m_result = r[3:0]; m_ov = r[4]; m_carry = r[5]; m_to = 1'b0;
            m_count = m_count + 4'd1;
            exp_q.push_back(exp_ledr(S_SHOW, 1'b0));
            repeat (resp_cycle - 1) @(negedge clk);
            bus.resp_valid = 1'b1; bus.resp_result = r[3:0];
            bus.resp_overflow = r[4]; bus.resp_carry = r[5];
            @(negedge clk);
            bus.resp_valid = 1'b0; bus.resp_result = $urandom_range(0, 15);
        end else begin
            m_result = '0; m_ov = 1'b0; m_carry = 1'b0; m_to = 1'b1;
            exp_q.push_back(exp_ledr(S_SHOW, 1'b0));
            repeat (15) @(negedge clk);
            checks++;
            if (ledr[10:8] !== S_RESP) begin
                errors++;
                $display("FAIL timeout_early: state=%0d after 15 cycles, want 4", ledr[10:8]);
            end
            @(negedge clk);
        end
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (ledr[10:8] === S_SHOW) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        exp = exp_q.pop_front();
        got = ledr;
        if (!found || got !== exp) begin
            errors++;
            $display("FAIL show_ledr: got %h want %h (reached_show=%b)", got, exp, found);
        end
    endtask

    task automatic leave_show();
        press_enter();
        checks++;
        if (ledr !== exp_ledr(S_A, 1'b0)) begin
            errors++;
            $display("FAIL leave_show: ledr=%h want %h", ledr, exp_ledr(S_A, 1'b0));
        end
    endtask

    task automatic test_reset();
        m_result = '0; m_count = '0; m_carry = 1'b0; m_ov = 1'b0; m_to = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ledr !== 16'h0000 || bus.req_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ledr=%h valid=%b busy=%b, want 0000 0 0",
                     ledr, bus.req_valid, busy);
        end
    endtask

    task automatic test_basic_add();
        run_txn(4'd7, 4'd2, OP_ADD, 1, 1);
        checks++;
        if (ledr !== 16'h1529) begin
            errors++;
            $display("FAIL add_7_2: ledr=%h want 1529", ledr);
        end
        leave_show();
    endtask

    task automatic test_ready_stall();
        run_txn(4'd5, 4'd3, OP_SUB, 5, 2);
        leave_show();
    endtask

    task automatic test_timeout();
        logic [3:0] cnt_before;
        cnt_before = m_count;
        run_txn(4'd9, 4'd4, OP_XOR, 0, 0);
        checks++;
        if (ledr[6] !== 1'b1 || ledr[3:0] !== 4'd0 || ledr[15:12] !== cnt_before) begin
            errors++;
            $display("FAIL timeout_flags: to=%b res=%h cnt=%h, want 1 0 %h",
                     ledr[6], ledr[3:0], ledr[15:12], cnt_before);
        end
        leave_show();
    endtask

    task automatic test_resp_on_last();
        run_txn(4'd3, 4'd3, OP_EQ, 2, 16);
        checks++;
        if (ledr[6] !== 1'b0 || ledr[3:0] !== 4'd1) begin
            errors++;
            $display("FAIL resp_last_cycle: to=%b res=%h, want 0 1", ledr[6], ledr[3:0]);
        end
        leave_show();
    endtask

    task automatic test_ignore_resp();
        bus.resp_valid = 1'b1; bus.resp_result = 4'hE;
        bus.resp_carry = 1'b1; bus.resp_overflow = 1'b1;
        @(negedge clk);
        bus.resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ledr !== exp_ledr(S_A, 1'b0)) begin
            errors++;
            $display("FAIL idle_resp_ignored: ledr=%h want %h", ledr, exp_ledr(S_A, 1'b0));
        end
    endtask

    task automatic test_clear_resp();
        enter_operands(4'd1, 4'd2, OP_OR);
        bus.req_ready = 1'b1;
        @(negedge clk);
        bus.req_ready = 1'b0;
        press_clr();
        checks++;
        if (ledr !== exp_ledr(S_A, 1'b0) || bus.req_valid !== 1'b0 ||
            bus.req_a !== 4'd0 || bus.req_b !== 4'd0 || bus.req_op !== 3'd0) begin
            errors++;
            $display("FAIL clear_in_resp: ledr=%h valid=%b a=%h b=%h op=%h, want %h 0 0 0 0",
                     ledr, bus.req_valid, bus.req_a, bus.req_b, bus.req_op, exp_ledr(S_A, 1'b0));
        end
        bus.resp_valid = 1'b1; bus.resp_result = 4'h3;
        @(negedge clk);
        bus.resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ledr !== exp_ledr(S_A, 1'b0)) begin
            errors++;
            $display("FAIL late_resp_ignored: ledr=%h want %h", ledr, exp_ledr(S_A, 1'b0));
        end
    endtask

    task automatic test_enter_hold();
        sw = 16'h0006;
        btn_enter = 1'b1;
        repeat (100) @(negedge clk);
        btn_enter = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (ledr[10:8] !== S_B || bus.req_a !== 4'd6) begin
            errors++;
            $display("FAIL enter_held: state=%0d a=%h, want 1 6", ledr[10:8], bus.req_a);
        end
        btn_clr = 1'b1; btn_enter = 1'b1;
        repeat (4) @(negedge clk);
        btn_clr = 1'b0; btn_enter = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ledr[10:8] !== S_A || bus.req_a !== 4'd0) begin
            errors++;
            $display("FAIL clear_over_enter: state=%0d a=%h, want 0 0", ledr[10:8], bus.req_a);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 14; n++) begin
            run_txn(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(1, 6));
            leave_show();
        end
    endtask

    task automatic test_rst_mid();
        enter_operands(4'd4, 4'd4, OP_AND);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.req_valid !== 1'b0 || ledr !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_req: valid=%b ledr=%h busy=%b, want 0 0000 0",
                     bus.req_valid, ledr, busy);
        end
        m_result = '0; m_count = '0; m_carry = 1'b0; m_ov = 1'b0; m_to = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ledr !== 16'h0000 || bus.req_a !== 4'd0) begin
            errors++;
            $display("FAIL rst_release: ledr=%h a=%h, want 0000 0", ledr, bus.req_a);
        end
    endtask

    initial begin
        bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_result = '0;
        bus.resp_carry = 1'b0; bus.resp_overflow = 1'b0;
        test_reset();
        test_basic_add();
        test_ready_stall();
        test_timeout();
        test_resp_on_last();
        test_ignore_resp();
        test_clear_resp();
        test_enter_hold();
        test_back_to_back();
        test_rst_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_requester.md
ALU_REQUESTER -- requirements
Module: alu_requester

Interface
REQ-001 Parameter ALU_WIDTH, default 4, operand/result width.
REQ-002 Parameter OP_WIDTH, default 3, opcode width.
REQ-003 Parameter TIMEOUT_CYC, default 16, maximum cycles waited for a response.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 sw  input  16  operator entry: sw[3:0] operand value, sw[15:13] opcode.
REQ-007 btn_enter  input  1  asynchronous push-button, confirms the current entry step.
REQ-008 btn_clr  input  1  asynchronous push-button, aborts and restarts entry.
REQ-009 req_valid  output  1  request to the ALU responder is valid.
REQ-010 req_ready  input  1  responder accepts the request.
REQ-011 req_op  output  OP_WIDTH  opcode, ADD=000 SUB=001 NOT=010 AND=011 OR=100 XOR=101 CMP=110 EQ=111.
REQ-012 req_a, req_b  output  ALU_WIDTH each  operands.
REQ-013 resp_valid  input  1  response strobe from responder.
REQ-014 resp_result  input  ALU_WIDTH; resp_carry  input  1; resp_overflow  input  1.
REQ-015 ledr  output  16  display: [3:0] result, [4] carry, [5] overflow, [6] timeout, [7] 0, [10:8] state code, [11] busy, [15:12] completed-op count.
REQ-016 busy  output  1  high in S_REQ and S_RESP.

Function
REQ-017 Each button SHALL pass through a 2-flop synchronizer, then rising-edge detection yielding a one-cycle pulse; a held button yields exactly one pulse.
REQ-018 FSM states and codes: S_A=0, S_B=1, S_OP=2, S_REQ=3, S_RESP=4, S_SHOW=5.
REQ-019 S_A: on enter pulse, latch sw[3:0] into A, go S_B.
REQ-020 S_B: on enter pulse, latch sw[3:0] into B, go S_OP.
REQ-021 S_OP: on enter pulse, latch sw[15:13] into OP, go S_REQ.
REQ-022 S_REQ: req_valid=1 with req_op/req_a/req_b stable; on cycle with req_ready=1 go S_RESP, clear wait counter.
REQ-023 S_RESP: req_valid=0; on resp_valid=1 latch result/carry/overflow, clear timeout flag, increment count (mod 16), go S_SHOW.
REQ-024 S_RESP timeout: if resp_valid not seen within TIMEOUT_CYC cycles after entering S_RESP, latch result=0, carry=0, overflow=0, set timeout flag, do not increment count, go S_SHOW.
REQ-025 resp_valid arriving on the same cycle the counter expires SHALL be treated as a valid response (response wins).
REQ-026 resp_valid outside S_RESP SHALL be ignored.
REQ-027 S_SHOW: display held; enter pulse returns to S_A; latched result stays displayed until next response/timeout.
REQ-028 Enter pulses in S_REQ/S_RESP SHALL be ignored.
REQ-029 Clear pulse in any state: go S_A next cycle, A=B=OP=0, req_valid=0, result/flags/count unchanged; clear has priority over enter on the same cycle.
REQ-030 Clear during S_REQ or S_RESP abandons the transaction; a late resp_valid is ignored per REQ-026.
REQ-031 req_op/req_a/req_b SHALL always reflect the OP/A/B registers.

Reset
REQ-032 On rst: state S_A; A, B, OP, result, carry, overflow, timeout, count, wait counter, synchronizers and edge registers = 0; req_valid=0, busy=0, ledr=16'h0000.
REQ-033 rst asserted mid-transaction SHALL drop req_valid asynchronously and discard any in-flight response.

Structure
REQ-034 Opcode constants, state codes and ALU_WIDTH/OP_WIDTH defaults SHALL reside in a shared package/header used by both requester and ALU responder.
REQ-035 Synchronizer plus edge detector SHALL be one sub-module, btn_pulse, instantiated twice.

Verification
REQ-036 Enter A=7, B=2, op=000; responder acks after 1 cycle, returns result 9 carry 0 overflow 1 -> ledr=16'h1529 (count 1, state 5).
REQ-037 req_ready held low 5 cycles in S_REQ -> req_valid stays 1 and operands stable all 5 cycles; no state change.
REQ-038 No resp_valid in S_RESP -> after 16 cycles ledr[6]=1, ledr[3:0]=0, count unchanged, state S_SHOW.
REQ-039 resp_valid on the 16th S_RESP cycle -> result latched, timeout=0, count incremented.
REQ-040 Clear pulse in S_RESP, then resp_valid -> state S_A, result/count unchanged; btn_enter held 100 cycles -> exactly one step advance.
REQ-041 rst asserted mid-S_REQ -> req_valid=0 immediately (before next edge), ledr=0, state S_A.
